// File: rtl/adc_capture_controller.sv
// ADC capture controller: captures a programmed number of 256-bit ADC beats
// starting at a TimeController counter value, buffers them in a small FIFO and
// streams them out as 128-bit words (header word first, then sample halves).
module adc_capture_controller #(
   parameter int unsigned AXIS_DATA_WIDTH = 256,
   parameter int unsigned OUT_DATA_WIDTH  = 128,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_aresetn,
   input  logic                       arm,
   input  logic [63:0]                start_time,
   input  logic [15:0]                sample_count,
   input  logic                       flush,
   input  logic [63:0]                counter,
   input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                       s00_axis_tvalid,
   output logic                       s00_axis_tready,
   output logic [OUT_DATA_WIDTH-1:0]  m00_axis_tdata,
   output logic                       m00_axis_tvalid,
   input  logic                       m00_axis_tready,
   output logic                       m00_axis_tlast,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic                       late
);

   localparam int unsigned ENTRY_W  = AXIS_DATA_WIDTH + 2;
   localparam int unsigned PTR_W    = FIFO_ADDR_WIDTH + 1;
   localparam int unsigned HDR_BIT  = AXIS_DATA_WIDTH + 1;
   localparam int unsigned LAST_BIT = AXIS_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t               r_state;
   logic [63:0]          r_start_time;
   logic [15:0]          r_sample_count;
   logic [15:0]          r_beat_cnt;
   logic                 r_overflow;
   logic                 r_late;
   logic                 r_tready;
   logic                 r_phase;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]           w_fill;
   logic                       w_empty;
   logic                       w_full;
   logic [ENTRY_W-1:0]         w_head;
   logic                       w_head_hdr;
   logic                       w_head_last;
   logic                       w_hs;
   logic                       w_final_word;
   logic                       w_start_hit;
   logic                       w_is_late;
   logic                       w_last_beat;
   logic                       w_cnt_zero;
   logic                       w_arm_ok;
   logic                       w_hdr_wr;
   logic                       w_beat;
   logic                       w_beat_wr;
   logic                       w_wr_en;
   logic [AXIS_DATA_WIDTH-1:0] w_hdr_data;
   logic [ENTRY_W-1:0]         w_wr_entry;

   // FIFO occupancy; full is judged on the pre-pop fill level
   assign w_fill  = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (w_fill == PTR_W'(FIFO_DEPTH));

   // Head-of-FIFO entry and serializer handshake
   assign w_head       = r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]];
   assign w_head_hdr   = w_head[HDR_BIT];
   assign w_head_last  = w_head[LAST_BIT];
   assign w_hs         = !w_empty && m00_axis_tready;
   assign w_final_word = w_head_hdr || r_phase;

   // Capture control decisions for this cycle; flush suppresses all of them
   assign w_start_hit = (counter >= r_start_time);
   assign w_is_late   = (counter > r_start_time);
   assign w_cnt_zero  = (r_sample_count == 16'd0);
   assign w_last_beat = (r_beat_cnt == (r_sample_count - 16'd1));
   assign w_arm_ok    = (r_state == ST_IDLE) && arm && w_empty && !flush;
   assign w_hdr_wr    = (r_state == ST_ARMED) && w_start_hit && !flush;
   assign w_beat      = (r_state == ST_CAPTURE) && s00_axis_tvalid && !flush;
   assign w_beat_wr   = w_beat && !w_full;
   assign w_wr_en     = w_hdr_wr || w_beat_wr;

   // Header payload: {late, sample_count, start counter}, upper bits zero
   assign w_hdr_data = AXIS_DATA_WIDTH'({w_is_late, r_sample_count, counter});
   assign w_wr_entry = w_hdr_wr ? {1'b1, w_cnt_zero, w_hdr_data}
                                : {1'b0, w_last_beat, s00_axis_tdata};

   // Output stream: low half first, high half second; header is a single word
   assign m00_axis_tvalid = !w_empty;
   assign m00_axis_tdata  = w_empty ? '0
                          : (r_phase ? w_head[AXIS_DATA_WIDTH-1:OUT_DATA_WIDTH]
                                     : w_head[OUT_DATA_WIDTH-1:0]);
   assign m00_axis_tlast  = !w_empty && w_head_last && w_final_word;

   // Status outputs
   assign s00_axis_tready = r_tready;
   assign busy            = (r_state != ST_IDLE);
   assign done            = (w_hdr_wr && w_cnt_zero) || (w_beat && w_last_beat);
   assign overflow        = r_overflow;
   assign late            = r_late;

   // FIFO storage; contents are only ever observed through valid pointers
   always_ff @(posedge s_axi_aclk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= w_wr_entry;
      end
   end

   // Capture FSM, FIFO pointers, serializer phase and sticky flags
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state        <= ST_IDLE;
         r_start_time   <= 64'd0;
         r_sample_count <= 16'd0;
         r_beat_cnt     <= 16'd0;
         r_overflow     <= 1'b0;
         r_late         <= 1'b0;
         r_tready       <= 1'b0;
         r_phase        <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
      end else begin
         r_tready <= 1'b1;
         if (flush) begin
            r_state  <= ST_IDLE;
            r_phase  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_en) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_hs) begin
               if (w_final_word) begin
                  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                  r_phase  <= 1'b0;
               end else begin
                  r_phase  <= 1'b1;
               end
            end
            case (r_state)
               ST_IDLE: begin
                  if (w_arm_ok) begin
                     r_start_time   <= start_time;
                     r_sample_count <= sample_count;
                     r_beat_cnt     <= 16'd0;
                     r_overflow     <= 1'b0;
                     r_late         <= 1'b0;
                     r_state        <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (w_hdr_wr) begin
                     if (w_is_late) begin
                        r_late <= 1'b1;
                     end
                     r_state <= w_cnt_zero ? ST_IDLE : ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  if (w_beat) begin
                     r_beat_cnt <= r_beat_cnt + 16'd1;
                     if (w_full) begin
                        r_overflow <= 1'b1;
                     end
                     if (w_last_beat) begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_controller.sv
// Directed bench for adc_capture_controller: table of capture scenarios plus
// hand-written overflow/stall, flush, arm-rejection and async-reset sequences.
module tb_adc_capture_controller;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         arm = 1'b0;
   logic [63:0]  start_time = 64'd0;
   logic [15:0]  sample_count = 16'd0;
   logic         flush = 1'b0;
   logic [63:0]  counter = 64'd0;
   logic [255:0] s_tdata = '0;
   logic         s_tvalid = 1'b1;
   logic         s_tready;
   logic [127:0] m_tdata;
   logic         m_tvalid;
   logic         m_tready = 1'b1;
   logic         m_tlast;
   logic         busy;
   logic         done;
   logic         overflow;
   logic         late;

   int           n_checks = 0;
   int           n_fail = 0;
   int           done_cnt = 0;
   logic         ramp = 1'b0;
   logic [127:0] got_data[$];
   logic         got_last[$];

   adc_capture_controller #(
      .AXIS_DATA_WIDTH(256),
      .OUT_DATA_WIDTH (128),
      .FIFO_DEPTH     (16),
      .FIFO_ADDR_WIDTH(4)
   ) dut (
      .s_axi_aclk     (clk),
      .s_axi_aresetn  (rst_n),
      .arm            (arm),
      .start_time     (start_time),
      .sample_count   (sample_count),
      .flush          (flush),
      .counter        (counter),
      .s00_axis_tdata (s_tdata),
      .s00_axis_tvalid(s_tvalid),
      .s00_axis_tready(s_tready),
      .m00_axis_tdata (m_tdata),
      .m00_axis_tvalid(m_tvalid),
      .m00_axis_tready(m_tready),
      .m00_axis_tlast (m_tlast),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow),
      .late           (late)
   );

   always #5 clk = ~clk;

   // Distinct ADC beat contents derived from the counter value of that cycle
   function automatic logic [255:0] beat_of(input logic [63:0] c);
      return {c ^ 64'hA5A5_0000_0000_5A5A, ~c, c + 64'h0123_4567_0000_0000, c};
   endfunction

   function automatic logic [127:0] hdr_of(input logic [63:0] c, input logic [15:0] n,
                                           input logic lt);
      return {47'd0, lt, n, c};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_counter(input logic [63:0] v);
      counter = v;
      s_tdata = beat_of(counter);
   endtask

   task automatic clear_log();
      got_data.delete();
      got_last.delete();
      done_cnt = 0;
   endtask

   // One clock: log handshakes and done in the current cycle, then advance
   task automatic tick();
      logic chk_after;
      #1;
      if (m_tvalid && m_tready) begin
         got_data.push_back(m_tdata);
         got_last.push_back(m_tlast);
      end
      chk_after = done;
      if (done) begin
         done_cnt++;
         check("busy_at_done", 128'(busy), 128'(1));
      end
      @(posedge clk);
      #1;
      if (ramp) counter = counter + 64'd1;
      s_tdata = beat_of(counter);
      if (chk_after) check("busy_after_done", 128'(busy), 128'(0));
   endtask

   task automatic pulse_arm(input logic [63:0] st, input logic [15:0] cnt);
      start_time   = st;
      sample_count = cnt;
      arm          = 1'b1;
      tick();
      arm          = 1'b0;
   endtask

   // Full capture with tready=1, then compare the collected words with the model
   task automatic run_capture(input logic [63:0] st, input logic [15:0] cnt,
                              input logic [63:0] a, input logic rmp,
                              input logic [63:0] exp_hdr, input logic exp_late,
                              input logic inject);
      int n_exp;
      logic [255:0] b;
      logic fin;
      clear_log();
      ramp     = rmp;
      m_tready = 1'b1;
      set_counter(a);
      pulse_arm(st, cnt);
      if (inject) pulse_arm(64'd0, 16'd7);
      fin = 1'b0;
      for (int i = 0; i < 600 && !fin; i++) begin
         tick();
         fin = (done_cnt > 0) && !m_tvalid && !busy;
      end
      check("capture_complete", 128'(fin), 128'(1));
      n_exp = 1 + 2 * int'(cnt);
      check("word_count", 128'(got_data.size()), 128'(n_exp));
      if (got_data.size() > 0) begin
         check("header", got_data[0], hdr_of(exp_hdr, cnt, exp_late));
         check("header_last", 128'(got_last[0]), 128'(cnt == 16'd0));
      end
      for (int k = 1; k <= int'(cnt); k++) begin
         b = beat_of(rmp ? exp_hdr + 64'(k) : exp_hdr);
         if (2 * k < got_data.size()) begin
            check("sample_lo", got_data[2*k-1], b[127:0]);
            check("sample_hi", got_data[2*k], b[255:128]);
            check("lo_last", 128'(got_last[2*k-1]), 128'(0));
            check("hi_last", 128'(got_last[2*k]), 128'(k == int'(cnt)));
         end
      end
      check("done_once", 128'(done_cnt), 128'(1));
      check("late_flag", 128'(late), 128'(exp_late));
      check("no_overflow", 128'(overflow), 128'(0));
   endtask

   typedef struct {
      logic [63:0] st;
      logic [15:0] cnt;
      logic [63:0] a;
      logic        rmp;
      logic [63:0] hdr;
      logic        lt;
      logic        inject;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [127:0] hdr;
      logic [255:0] b;
      logic         fin;

      vecs[0] = '{64'd100, 16'd3, 64'd0,   1'b1, 64'd100, 1'b0, 1'b0};
      vecs[1] = '{64'd50,  16'd2, 64'd80,  1'b0, 64'd80,  1'b1, 1'b0};
      vecs[2] = '{64'd10,  16'd0, 64'd10,  1'b0, 64'd10,  1'b0, 1'b0};
      vecs[3] = '{64'd200, 16'd1, 64'd190, 1'b1, 64'd200, 1'b0, 1'b0};
      vecs[4] = '{64'd300, 16'd2, 64'd290, 1'b1, 64'd300, 1'b0, 1'b1};

      // Reset values
      #12;
      check("rst_s_tready", 128'(s_tready), 128'(0));
      check("rst_tvalid", 128'(m_tvalid), 128'(0));
      check("rst_tlast", 128'(m_tlast), 128'(0));
      check("rst_tdata", m_tdata, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_overflow", 128'(overflow), 128'(0));
      check("rst_late", 128'(late), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("s_tready_after_rst", 128'(s_tready), 128'(1));

      // Table-driven captures
      foreach (vecs[i]) begin
         run_capture(vecs[i].st, vecs[i].cnt, vecs[i].a, vecs[i].rmp,
                     vecs[i].hdr, vecs[i].lt, vecs[i].inject);
      end

      // Overflow with output stalled: header + 15 samples fit, 5 beats dropped
      clear_log();
      m_tready = 1'b0;
      ramp     = 1'b1;
      set_counter(64'd1000);
      pulse_arm(64'd1001, 16'd20);
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         tick();
         fin = (done_cnt > 0);
      end
      check("ovf_done_seen", 128'(fin), 128'(1));
      check("ovf_flag", 128'(overflow), 128'(1));
      check("ovf_busy", 128'(busy), 128'(0));
      hdr = hdr_of(64'd1001, 16'd20, 1'b0);
      // Arm while FIFO holds data is ignored
      pulse_arm(64'd0, 16'd5);
      check("arm_ignored_nonempty", 128'(busy), 128'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", 128'(m_tvalid), 128'(1));
         check("stall_data", m_tdata, hdr);
         check("stall_last", 128'(m_tlast), 128'(0));
      end
      check("stall_no_handshake", 128'(got_data.size()), 128'(0));
      m_tready = 1'b1;
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         tick();
         fin = !m_tvalid;
      end
      check("ovf_drained", 128'(fin), 128'(1));
      check("ovf_word_count", 128'(got_data.size()), 128'(31));
      if (got_data.size() == 31) begin
         check("ovf_header", got_data[0], hdr);
         for (int k = 1; k <= 15; k++) begin
            b = beat_of(64'd1001 + 64'(k));
            check("ovf_lo", got_data[2*k-1], b[127:0]);
            check("ovf_hi", got_data[2*k], b[255:128]);
         end
         foreach (got_last[j]) check("ovf_no_tlast", 128'(got_last[j]), 128'(0));
      end

      // Flush mid-capture with output stalled, then a clean capture
      clear_log();
      m_tready = 1'b0;
      ramp     = 1'b1;
      set_counter(64'd2000);
      pulse_arm(64'd2001, 16'd10);
      for (int i = 0; i < 6; i++) tick();
      check("pre_flush_valid", 128'(m_tvalid), 128'(1));
      check("pre_flush_busy", 128'(busy), 128'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_tvalid", 128'(m_tvalid), 128'(0));
      check("flush_busy", 128'(busy), 128'(0));
      check("flush_no_done", 128'(done_cnt), 128'(0));
      run_capture(64'd2050, 16'd2, 64'd2040, 1'b1, 64'd2050, 1'b0, 1'b0);

      // Asynchronous reset mid-capture
      m_tready = 1'b0;
      set_counter(64'd3000);
      pulse_arm(64'd3001, 16'd8);
      for (int i = 0; i < 4; i++) tick();
      check("pre_reset_busy", 128'(busy), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_tvalid", 128'(m_tvalid), 128'(0));
      check("async_rst_busy", 128'(busy), 128'(0));
      check("async_rst_s_tready", 128'(s_tready), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
